p4_router_egress_demux: RTL
===========================

// Module: p4_router_egress_demux
// PURPOSE
//  Downstream of the VNP4 wrapper-select stage. Pairs each packet leaving the P4 pipeline with its
//  per-packet sideband metadata (egress-spec + ingress-port, single-cycle valid), then steers
//  the whole packet to one of NUM_PORTS egress AXIS ports, or discards it when the spec is invalid.
//  Metadata may arrive before, with, or after the packet's first beat; a small FIFO decouples them.
// PARAMETERS
//  NUM_PORTS                4   number of egress AXIS ports (2..16)
//  EGR_SPEC_METADATA_WIDTH  4   egress-spec width; must be >= $clog2(NUM_PORTS)
//  ING_PORT_METADATA_WIDTH  4   ingress-port width; carried through to the per-port tuser
//  DATA_BYTES               64  AXIS data bytes; must equal DATA_BYTES on packet_in and every packet_out
//  META_FIFO_DEPTH          8   metadata FIFO entries; power of 2, >= 2
// PORTS
//  clk                      in   1     single clock for all logic
//  areset                   in   1     asynchronous active-high reset
//  packet_in                AXIS_int.Slave     packet data from the VNP4 wrapper
//  meta_in_egr_spec         in   EGR_SPEC_METADATA_WIDTH   egress spec from VNP4
//  meta_in_ing_port         in   ING_PORT_METADATA_WIDTH   ingress port from VNP4
//  meta_in_valid            in   1     one pulse per packet, qualifies both meta_in_* fields
//  packet_out[NUM_PORTS]    AXIS_int.Master    egress ports; tuser = ing_port metadata
//  fwd_pkt_count            out  32    packets forwarded (all ports), saturating
//  drop_pkt_count           out  32    packets discarded, saturating
//  meta_overflow            out  1     sticky: meta_in_valid seen while FIFO full
// BEHAVIOUR
//  Reset (async assert, sync deassert internally): FSM=IDLE, FIFO empty, counters 0,
//   meta_overflow 0, packet_in.tready 0, all packet_out tvalid 0.
//  Metadata FIFO: push {egr_spec, ing_port} on meta_in_valid. Pushing while full drops the entry and
//   sets meta_overflow. Pop occurs on the accepted tlast beat. Push and pop in the same cycle
//   while full is legal: no overflow, and occupancy is unchanged.
//  FSM:
//   IDLE: packet_in.tready=0. If the FIFO is non-empty, register the head entry. Go to FWD when
//    egr_spec < NUM_PORTS; otherwise go to DROP. This costs 1 cycle.
//   FWD: packet_out[sel].tvalid = packet_in.tvalid. tdata/tkeep/tlast pass through combinationally.
//    tuser = the registered ing_port. packet_in.tready = packet_out[sel].tready.
//    Non-selected ports hold tvalid 0. On the accepted tlast: pop, increment fwd_pkt_count, go to IDLE.
//   DROP: packet_in.tready=1 and beats are discarded. On the accepted tlast: pop, increment
//    drop_pkt_count, go to IDLE.
//  Latency: 0 cycles per beat in FWD. 1 bubble cycle between packets (IDLE).
//  tvalid on the selected port must not drop without a handshake, because it mirrors an upstream that
//   obeys AXIS. The block never deasserts tready mid-beat on its own.
//  Counters saturate at 32'hFFFF_FFFF and never wrap.
//  Single-beat packets (tlast on the first beat) are legal and complete in 1 FWD/DROP cycle.
//  Reset mid-packet: remaining beats belong to upstream, which shares the reset.
//   No partial-packet recovery is required.
// TESTING
//  1. Metadata spec=2 arrives 3 cycles before a 4-beat packet -> all 4 beats on port 2 only, tuser=ing_port,
//     fwd_pkt_count=1.
//  2. Spec=7 with NUM_PORTS=4 on a 3-beat packet -> tready=1 for 3 beats, no tvalid on any port, drop_pkt_count=1.
//  3. Port 1 tready held low for 5 cycles mid-packet -> packet_in.tready low for exactly those cycles;
//     no beat lost or duplicated.
//  4. 10 metadata pulses with FIFO depth 8 and no packets -> meta_overflow=1 after the 9th pulse;
//     the first 8 packets route per specs 1..8.
//  5. Back-to-back 1-beat packets to ports 0,1,2,3 -> each appears once, on the correct port,
//     with 1 idle cycle between packets.
//  6. areset asserted mid-packet -> all tvalid=0 and counters=0 in the same cycle; the next packet
//     routes correctly.

Source files
------------

// File: rtl/p4_router_egress_demux.sv
// Egress demux behind the VNP4 pipeline: pairs each packet with its queued sideband metadata
// and steers the whole packet to one AXIS egress port, or drops it when the egress spec is out of range.
module p4_router_egress_demux #(
    parameter int NUM_PORTS               = 4,
    parameter int EGR_SPEC_METADATA_WIDTH = 4,
    parameter int ING_PORT_METADATA_WIDTH = 4,
    parameter int DATA_BYTES              = 64,
    parameter int META_FIFO_DEPTH         = 8
) (
    input  logic                                                clk,
    input  logic                                                areset,
    input  logic [DATA_BYTES*8-1:0]                             packet_in_tdata,
    input  logic [DATA_BYTES-1:0]                               packet_in_tkeep,
    input  logic                                                packet_in_tlast,
    input  logic                                                packet_in_tvalid,
    output logic                                                packet_in_tready,
    input  logic [EGR_SPEC_METADATA_WIDTH-1:0]                  meta_in_egr_spec,
    input  logic [ING_PORT_METADATA_WIDTH-1:0]                  meta_in_ing_port,
    input  logic                                                meta_in_valid,
    output logic [NUM_PORTS-1:0][DATA_BYTES*8-1:0]              packet_out_tdata,
    output logic [NUM_PORTS-1:0][DATA_BYTES-1:0]                packet_out_tkeep,
    output logic [NUM_PORTS-1:0]                                packet_out_tlast,
    output logic [NUM_PORTS-1:0][ING_PORT_METADATA_WIDTH-1:0]   packet_out_tuser,
    output logic [NUM_PORTS-1:0]                                packet_out_tvalid,
    input  logic [NUM_PORTS-1:0]                                packet_out_tready,
    output logic [31:0]                                         fwd_pkt_count,
    output logic [31:0]                                         drop_pkt_count,
    output logic                                                meta_overflow
);

    localparam int AW    = $clog2(META_FIFO_DEPTH);
    localparam int SEL_W = $clog2(NUM_PORTS);
    localparam int EGR_W = EGR_SPEC_METADATA_WIDTH;
    localparam int ING_W = ING_PORT_METADATA_WIDTH;
    localparam logic [EGR_W:0] NUM_PORTS_EXT = (EGR_W+1)'(NUM_PORTS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    logic [1:0]       rst_pipe_r;
    logic             rst_s;
    state_t           state_r;
    state_t           state_s;
    logic [SEL_W-1:0] sel_r;
    logic [ING_W-1:0] ing_r;

    logic [EGR_W-1:0] fifo_egr_r [META_FIFO_DEPTH];
    logic [ING_W-1:0] fifo_ing_r [META_FIFO_DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             head_fwd_s;
    logic [EGR_W-1:0] head_egr_s;
    logic [ING_W-1:0] head_ing_s;

    // Reset synchronizer: asserts immediately with areset, releases on a clock edge.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rst_pipe_r <= 2'b11;
        end else begin
            rst_pipe_r <= {rst_pipe_r[0], 1'b0};
        end
    end

    assign rst_s = rst_pipe_r[1];

    assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign pop_s      = packet_in_tvalid && packet_in_tready && packet_in_tlast;
    // A pop in the same cycle frees the slot, so a push while full is still accepted.
    assign push_s     = meta_in_valid && (!full_s || pop_s);
    assign head_egr_s = fifo_egr_r[rd_ptr_r[AW-1:0]];
    assign head_ing_s = fifo_ing_r[rd_ptr_r[AW-1:0]];
    assign head_fwd_s = ({1'b0, head_egr_s} < NUM_PORTS_EXT);

    // Metadata FIFO storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_egr_r[wr_ptr_r[AW-1:0]] <= meta_in_egr_spec;
            fifo_ing_r[wr_ptr_r[AW-1:0]] <= meta_in_ing_port;
        end
    end

    // FIFO pointers and sticky overflow flag.
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            meta_overflow <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
            if (meta_in_valid && full_s && !pop_s) begin
                meta_overflow <= 1'b1;
            end
        end
    end

    // State register plus the routing decision captured when leaving IDLE.
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            state_r <= ST_IDLE;
            sel_r   <= '0;
            ing_r   <= '0;
        end else begin
            state_r <= state_s;
            if (state_r == ST_IDLE && !empty_s) begin
                sel_r <= head_egr_s[SEL_W-1:0];
                ing_r <= head_ing_s;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    state_s = head_fwd_s ? ST_FWD : ST_DROP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FWD, ST_DROP: begin
                if (pop_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Datapath: payload is broadcast, only the selected port sees tvalid.
    always_comb begin
        packet_in_tready  = 1'b0;
        packet_out_tvalid = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            packet_out_tdata[p] = packet_in_tdata;
            packet_out_tkeep[p] = packet_in_tkeep;
            packet_out_tlast[p] = packet_in_tlast;
            packet_out_tuser[p] = ing_r;
        end
        case (state_r)
            ST_FWD: begin
                packet_out_tvalid[sel_r] = packet_in_tvalid;
                packet_in_tready         = packet_out_tready[sel_r];
            end
            ST_DROP: begin
                packet_in_tready = 1'b1;
            end
            default: begin
                packet_in_tready = 1'b0;
            end
        endcase
    end

    // Saturating packet counters.
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            fwd_pkt_count  <= 32'd0;
            drop_pkt_count <= 32'd0;
        end else begin
            if (pop_s && state_r == ST_FWD && fwd_pkt_count != 32'hFFFF_FFFF) begin
                fwd_pkt_count <= fwd_pkt_count + 32'd1;
            end
            if (pop_s && state_r == ST_DROP && drop_pkt_count != 32'hFFFF_FFFF) begin
                drop_pkt_count <= drop_pkt_count + 32'd1;
            end
        end
    end

endmodule
